// File: rtl/poly_view_pkg.sv
// poly_view_pkg: shared types and constants for the poly result viewer
package poly_view_pkg;
  localparam int DATA_W = 12;
  localparam int IDX_W = 4;
  localparam logic [15:0] LED_IDLE = 16'hFFFF;
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_VIEW} state_t;
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i, input int depth);
    return (int'(i) == depth - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer, stability counter and rising-edge pulse
module button_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  logic [1:0] sync_q, sync_d;
  logic level_q, level_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // count consecutive cycles the synced input disagrees with the accepted level
  always_comb begin
    sync_d = {sync_q[0], btn};
    level_d = (sync_q[1] != level_q && cnt_q == CNT_LAST) ? sync_q[1] : level_q;
    cnt_d = (sync_q[1] == level_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    pulse_d = level_d & ~level_q;
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level_q <= 1'b0;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/poly_result_viewer.sv
// poly_result_viewer: capture a burst of multiplier results, then step through them on the LEDs
module poly_result_viewer
  import poly_view_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKIP = 0,
  parameter int DEBOUNCE = 4
) (
  input  logic              man_clk,
  input  logic              man_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              step,
  output logic [15:0]       LED,
  output logic              busy,
  output logic              done
);
  localparam int SW = SKIP > 1 ? $clog2(SKIP) : 1;
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP > 0 ? SKIP - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [15:0] led_q, led_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic step_pulse;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
    .clk(man_clk),
    .rst(man_reset),
    .btn(step),
    .pulse(step_pulse)
  );

  // sequencing: start restarts everything from any state; steps only count in VIEW
  always_comb begin
    state_d = state_q;
    skip_d = skip_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    if (start) begin
      state_d = (SKIP == 0) ? S_CAPTURE : S_SKIP;
      skip_d = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      case (state_q)
        S_SKIP: begin
          state_d = (skip_q == SKIP_LAST) ? S_CAPTURE : S_SKIP;
          skip_d = skip_q + 1'b1;
        end
        S_CAPTURE: begin
          state_d = (wr_idx_q == IDX_LAST) ? S_VIEW : S_CAPTURE;
          wr_idx_d = wr_idx_q + 1'b1;
        end
        S_VIEW: rd_idx_d = step_pulse ? idx_next(rd_idx_q, DEPTH) : rd_idx_q;
        default: ;
      endcase
    end
  end

  // buffer write during capture and read mux for the viewed word
  always_comb begin
    mem_d = mem_q;
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q == S_CAPTURE && !start && wr_idx_q == IDX_W'(i)) mem_d[i] = din;
      if (rd_idx_q == IDX_W'(i)) rd_word = mem_q[i];
    end
  end

  // LED source selected by the current state, registered one edge later
  always_comb begin
    led_d = state_q == S_IDLE ? LED_IDLE : state_q == S_VIEW ? {rd_idx_q, rd_word} : {wr_idx_q, din};
  end

  // control registers with asynchronous reset
  always_ff @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      state_q <= S_IDLE;
      skip_q <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      led_q <= led_d;
    end
  end

  // capture buffer is plain registers and keeps its contents across reset
  always_ff @(posedge man_clk) begin
    mem_q <= mem_d;
  end

  assign busy = state_q == S_SKIP || state_q == S_CAPTURE;
  assign done = state_q == S_VIEW;
  assign LED = led_q;
endmodule

// File: tb/tb_poly_result_viewer.sv
// tb_poly_result_viewer: two configurations checked against a behavioural capture/replay model
module tb_poly_result_viewer;
  localparam int DB = 4;
  logic man_clk = 0, man_reset = 0, start = 0, step = 0;
  logic [11:0] din = 0;
  logic [15:0] led_o [2];
  logic busy_o [2];
  logic done_o [2];
  int checks = 0, failures = 0, hold = 0;
  bit armed = 0;

  poly_result_viewer #(.DEPTH(4), .SKIP(0), .DEBOUNCE(DB)) u0 (
    .man_clk(man_clk), .man_reset(man_reset), .start(start), .din(din), .step(step),
    .LED(led_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  poly_result_viewer #(.DEPTH(16), .SKIP(2), .DEBOUNCE(DB)) u1 (
    .man_clk(man_clk), .man_reset(man_reset), .start(start), .din(din), .step(step),
    .LED(led_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  always #5 man_clk = ~man_clk;

  function automatic int dep(int j);
    return j == 0 ? 4 : 16;
  endfunction
  function automatic int skp(int j);
    return j == 0 ? 0 : 2;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge man_clk);
    #1;
  endtask

  task automatic press();
    step = 1;
    repeat (DB + 6) tick();
    step = 0;
    repeat (DB + 6) tick();
  endtask

  // model: n = edges since the start edge (-1 when idle); words land at n = SKIP+1+k
  int n_m [2];
  int rd_m [2];
  logic [11:0] mem_m [2][16];
  logic [15:0] led_m [2];
  logic lvl_m = 0, pulse_m = 0;
  logic [15:0] hist_m = 0;
  int d, s, p;
  initial for (int j = 0; j < 2; j++) begin n_m[j] = -1; rd_m[j] = 0; led_m[j] = 0; end

  always @(posedge man_clk or posedge man_reset) begin
    if (man_reset) begin
      for (int j = 0; j < 2; j++) begin n_m[j] = -1; rd_m[j] = 0; led_m[j] = 0; end
      lvl_m = 0;
      pulse_m = 0;
      hist_m = 0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        d = dep(j);
        s = skp(j);
        p = n_m[j];
        led_m[j] = p < 0 ? 16'hFFFF : p < s + d ? {4'(p < s ? 0 : p - s), din} : {4'(rd_m[j]), mem_m[j][rd_m[j]]};
        if (!start && p >= s && p < s + d) mem_m[j][p - s] = din;
        rd_m[j] = start ? 0 : (p >= s + d && pulse_m) ? (rd_m[j] + 1) % d : rd_m[j];
        n_m[j] = start ? 0 : (p < 0 || p > 1000) ? p : p + 1;
      end
      hist_m = {hist_m[14:0], step};
      pulse_m = 0;
      if (hist_m[DB+1:2] == {DB{~lvl_m}}) begin
        lvl_m = ~lvl_m;
        pulse_m = lvl_m;
      end
    end
  end

  always @(negedge man_clk) begin
    if (armed) begin
      for (int j = 0; j < 2; j++)
        check(j == 0 ? "model_u0 {led,busy,done}" : "model_u1 {led,busy,done}",
              {14'd0, led_o[j], busy_o[j], done_o[j]},
              {14'd0, led_m[j], 1'(n_m[j] >= 0 && n_m[j] < skp(j) + dep(j)), 1'(n_m[j] >= skp(j) + dep(j))});
    end
  end

  initial begin
    #1 man_reset = 1;
    #1 armed = 1;
    tick();
    tick();
    check("led_in_reset", led_o[0], 16'h0000);
    check("busy_in_reset", busy_o[1], 0);
    man_reset = 0;
    repeat (3) tick();
    check("led_idle_u0", led_o[0], 16'hFFFF);
    check("led_idle_u1", led_o[1], 16'hFFFF);
    check("done_idle", done_o[0], 0);
    // capture of four known words with SKIP=0
    start = 1;
    tick();
    start = 0;
    check("busy_at_start", busy_o[0], 1);
    din = 12'h111; tick();
    din = 12'h222; tick();
    din = 12'h333; tick();
    check("done_before_t4", done_o[0], 0);
    din = 12'h444; tick();
    check("done_at_t4", done_o[0], 1);
    din = 12'h000; tick();
    check("led_first_word", led_o[0], 16'h0111);
    press(); check("step1", led_o[0], 16'h1222);
    press(); check("step2", led_o[0], 16'h2333);
    press(); check("step3", led_o[0], 16'h3444);
    press(); check("step_wrap", led_o[0], 16'h0111);
    step = 1; tick(); tick(); step = 0;
    repeat (12) tick();
    check("glitch_ignored", led_o[0], 16'h0111);
    // SKIP=2 DEPTH=16 capture of cycle counts, with a press during capture
    tick();
    start = 1;
    tick();
    start = 0;
    for (int n = 1; n <= 19; n++) begin
      din = 12'(n);
      step = (n >= 4 && n < 14);
      tick();
      if (n == 17) check("u1_done_t17", done_o[1], 0);
      if (n == 18) check("u1_done_t18", done_o[1], 1);
      if (n == 19) check("u1_mem0", led_o[1], 16'h0003);
    end
    press();
    check("u1_mem1", led_o[1], 16'h1004);
    // restart in the middle of a capture
    tick();
    start = 1;
    tick();
    start = 0;
    for (int n = 1; n <= 7; n++) begin din = 12'(n); tick(); end
    start = 1;
    din = 12'h008;
    tick();
    start = 0;
    check("restart_done_low", done_o[1], 0);
    for (int m = 1; m <= 19; m++) begin
      din = 12'h500 + 12'(m);
      tick();
      if (m == 17) check("restart_done_t17", done_o[1], 0);
      if (m == 18) check("restart_done_t18", done_o[1], 1);
      if (m == 19) check("restart_mem0", led_o[1], 16'h0503);
    end
    // reset in the middle of a capture
    start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    man_reset = 1;
    #1;
    check("rst_led", led_o[1], 16'h0000);
    check("rst_busy", busy_o[1], 0);
    check("rst_done", done_o[0], 0);
    tick();
    man_reset = 0;
    repeat (3) tick();
    check("after_rst_idle", led_o[1], 16'hFFFF);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 59) == 0);
      din = 12'($urandom);
      if (hold == 0) begin
        step = ~step;
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 1499) == 0) begin
        man_reset = 1;
        tick();
        man_reset = 0;
      end
      tick();
    end
    start = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
